// File: rtl/ntru_pkg.sv
// ntru_pkg
// Shared types and constants for the HRSS encapsulation datapath.
//   NUM_BIT      coefficient width, q = 2^NUM_BIT
//   Q_MASK       mask reducing a value mod q
//   coef_t       one coefficient mod q
//   tern_t       two-bit ternary digit encoding (10 is illegal)
//   mac_state_t  states of the ternary MAC controller
package ntru_pkg;

    localparam int NUM_BIT = 13;
    localparam logic [NUM_BIT-1:0] Q_MASK = 13'h1FFF;

    typedef logic [NUM_BIT-1:0] coef_t;

    typedef enum logic [1:0] {
        T_ZERO = 2'b00,
        T_POS  = 2'b01,
        T_NEG  = 2'b11
    } tern_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } mac_state_t;

    // The only code point without a meaning is 2'b10.
    function automatic logic tern_illegal(input logic [1:0] digit);
        return digit == 2'b10;
    endfunction

endpackage

// File: rtl/add_2i13_o13.sv
// add_2i13_o13
// Two-input 13-bit Kogge-Stone prefix adder; carry-out is dropped so the
// result is the sum mod 2^13.
//   i_x1, i_x2   addends
//   o_sum        (i_x1 + i_x2) mod 8192
module add_2i13_o13
    import ntru_pkg::*;
(
    input  coef_t i_x1,
    input  coef_t i_x2,
    output coef_t o_sum
);

    coef_t w_p0;
    coef_t w_g;
    coef_t w_p;
    coef_t w_carry;

    // Prefix tree: after level k, w_g[i] is the generate of span 2^(k+1)
    // ending at bit i. Shifting lines up bit i with bit i-d; the low d bits
    // keep their propagate because nothing lies below them.
    always_comb begin
        w_p0 = i_x1 ^ i_x2;
        w_g  = i_x1 & i_x2;
        w_p  = w_p0;
        for (int lv = 0; lv < 4; lv++) begin
            w_g = w_g | (w_p & (w_g << (1 << lv)));
            w_p = w_p & ((w_p << (1 << lv)) | coef_t'((13'd1 << (1 << lv)) - 13'd1));
        end
        w_carry = {w_g[NUM_BIT-2:0], 1'b0};
        o_sum   = (w_p0 ^ w_carry) & Q_MASK;
    end

endmodule

// File: rtl/ternary_mac_lane.sv
// ternary_mac_lane
// One accumulator lane: stage 1 registers the operand 0 / a / -a selected by
// the ternary digit, stage 2 adds it into the accumulator mod 2^13.
//   clk, rst_n   clock, synchronous active-low reset
//   i_clear      zero the accumulator and drop any in-flight operand
//   i_load       a beat is accepted this cycle
//   i_coef       broadcast coefficient a
//   i_tern       this lane's digit
//   o_acc        accumulator value
//   o_illegal    current digit is the illegal code 10
module ternary_mac_lane
    import ntru_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_load,
    input  coef_t      i_coef,
    input  logic [1:0] i_tern,
    output coef_t      o_acc,
    output logic       o_illegal
);

    coef_t w_neg;
    coef_t w_op;
    coef_t w_sum;
    coef_t r_op;
    coef_t r_acc;
    logic  r_op_valid;

    // Two's complement negation reuses the adder: ~a + 1.
    add_2i13_o13 u_neg (
        .i_x1  (~i_coef),
        .i_x2  (13'd1),
        .o_sum (w_neg)
    );

    always_comb begin
        w_op      = '0;
        o_illegal = tern_illegal(i_tern);
        case (i_tern)
            T_POS:   w_op = i_coef;
            T_NEG:   w_op = w_neg;
            default: w_op = '0;
        endcase
    end

    add_2i13_o13 u_acc (
        .i_x1  (r_acc),
        .i_x2  (r_op),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_op       <= '0;
            r_op_valid <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_op_valid <= i_load;
            if (i_load) begin
                r_op <= w_op;
            end
            if (r_op_valid) begin
                r_acc <= w_sum;
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/ternary_mac_q13.sv
// ternary_mac_q13
// Multi-lane ternary multiply-accumulate mod 2^13. Each beat broadcasts one
// coefficient and one ternary digit per lane; each lane does acc += t*a.
//   clk, rst_n            clock, synchronous active-low reset
//   start                 open a new product (honoured in IDLE only)
//   in_valid/in_ready     input beat handshake
//   in_coef               coefficient a
//   in_tern               lane i digit at [2i+1:2i]
//   in_last               final beat of the product
//   out_valid/out_ready   result handshake
//   out_acc               lane i result at [13i+12:13i]
//   busy                  controller not idle
//   err                   sticky: illegal digit or beat overrun
module ternary_mac_q13
    import ntru_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int NUM_BIT   = 13,
    parameter int MAX_TERMS = 701
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_BIT-1:0]         in_coef,
    input  logic [2*LANES-1:0]         in_tern,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_BIT*LANES-1:0]   out_acc,
    output logic                       busy,
    output logic                       err
);

    localparam int CNT_W = $clog2(MAX_TERMS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS);

    mac_state_t       r_state;
    mac_state_t       w_state_next;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_err;
    logic             w_accept;
    logic             w_start_ok;
    logic [LANES-1:0] w_lane_illegal;

    assign w_accept   = (r_state == ST_ACCUM) && in_valid;
    assign w_start_ok = (r_state == ST_IDLE) && start;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_state_next = ST_DRAIN;
            end
            // Last operand sits in stage 1; this cycle folds it into the sums.
            ST_DRAIN: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_beat_cnt <= '0;
                r_err      <= 1'b0;
            end else if (w_accept) begin
                if (r_beat_cnt < CNT_MAX) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                // Beat number MAX_TERMS+1 (or later) without in_last overruns.
                if ((|w_lane_illegal) || (r_beat_cnt >= CNT_LAST && !in_last)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign err = r_err;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        ternary_mac_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_clear   (w_start_ok),
            .i_load    (w_accept),
            .i_coef    (in_coef),
            .i_tern    (in_tern[2*gi +: 2]),
            .o_acc     (out_acc[NUM_BIT*gi +: NUM_BIT]),
            .o_illegal (w_lane_illegal[gi])
        );
    end

endmodule

// File: tb/tb_ternary_mac_q13.sv
module tb_ternary_mac_q13;

    localparam int LANES = 4;
    localparam int MAXT  = 701;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [12:0]          in_coef;
    logic [2*LANES-1:0]   in_tern;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [13*LANES-1:0]  out_acc;
    logic                 busy;
    logic                 err;

    always #5 clk = ~clk;

    ternary_mac_q13 #(.LANES(LANES), .NUM_BIT(13), .MAX_TERMS(MAXT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .in_tern   (in_tern),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .busy      (busy),
        .err       (err)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [12:0]         model [LANES];
    logic [13*LANES-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13*LANES-1:0] pack_model();
        logic [13*LANES-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[13*l +: 13] = model[l];
        return r;
    endfunction

    function automatic logic [2*LANES-1:0] rand_tern();
        logic [2*LANES-1:0] t;
        int r;
        t = '0;
        for (int l = 0; l < LANES; l++) begin
            r = $urandom_range(0, 2);
            t[2*l +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
        end
        return t;
    endfunction

    task automatic start_product();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int l = 0; l < LANES; l++) model[l] = '0;
        check("start_busy", busy, 1);
        check("start_err_clr", err, 0);
    endtask

    task automatic send_beat(input logic [12:0] a, input logic [2*LANES-1:0] t, input logic last);
        in_valid = 1'b1;
        in_coef  = a;
        in_tern  = t;
        in_last  = last;
        check("in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            case (t[2*l +: 2])
                2'b01:   model[l] = model[l] + a;
                2'b11:   model[l] = model[l] - a;
                default: model[l] = model[l];
            endcase
        end
        if (last) exp_q.push_back(pack_model());
    endtask

    // Entered one cycle after the last beat was accepted (DRAIN).
    task automatic collect(input string tag, input int hold);
        int n;
        logic [13*LANES-1:0] expv;
        n = 0;
        expv = '0;
        out_ready = (hold == 0);
        check({tag, "_drain"}, out_valid, 0);
        tick();
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 0);
        check({tag, "_sb_nonempty"}, exp_q.size(), 1);
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        check({tag, "_acc"}, out_acc, expv);
        for (int h = 0; h < hold; h++) begin
            start = (h == 4);
            tick();
            start = 1'b0;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_acc"}, out_acc, expv);
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 0);
        $display("[TB] %s result lane0=%0d lane1=%0d lane2=%0d lane3=%0d", tag,
                 out_acc[12:0], out_acc[25:13], out_acc[38:26], out_acc[51:39]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_out_acc"}, out_acc, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_coef = '0;
        in_tern = '0; in_last = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_reset_state("reset");

        // Single +1 beat, latency T+2.
        start_product();
        send_beat(13'd5, {LANES{2'b01}}, 1'b1);
        collect("single", 0);

        // Lane0: +100 -40 -70 = -10 -> 8182.
        start_product();
        send_beat(13'd100, 8'b00000001, 1'b0);
        send_beat(13'd40,  8'b00000011, 1'b0);
        send_beat(13'd70,  8'b00000011, 1'b1);
        collect("negate", 0);

        // Carry wrap: 8191 + 8191 -> 8190.
        start_product();
        send_beat(13'd8191, {LANES{2'b01}}, 1'b0);
        send_beat(13'd8191, {LANES{2'b01}}, 1'b1);
        collect("carry", 0);

        // 701 random beats with random gaps.
        start_product();
        for (int i = 0; i < MAXT; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                    tick();
                    check("gap_ready", in_ready, 1);
                end
            end
            send_beat(13'($urandom_range(0, 8191)), rand_tern(), i == MAXT - 1);
        end
        check("random_no_err", err, 0);
        collect("random", 0);

        // Backpressure: held 10 cycles, start ignored while in HOLD.
        start_product();
        send_beat(13'd1234, 8'b11010001, 1'b0);
        send_beat(13'd4321, 8'b01110100, 1'b1);
        collect("backpressure", 10);

        // Illegal digit on lane1.
        start_product();
        send_beat(13'd7, 8'b01011001, 1'b1);
        check("illegal_err", err, 1);
        collect("illegal", 0);
        check("illegal_err_sticky", err, 1);

        // Overrun: 702 beats without last.
        start_product();
        for (int i = 0; i < MAXT; i++) send_beat(13'($urandom_range(0, 8191)), rand_tern(), 1'b0);
        check("overrun_at_max", err, 0);
        send_beat(13'd11, rand_tern(), 1'b0);
        check("overrun_err", err, 1);
        send_beat(13'd22, rand_tern(), 1'b1);
        collect("overrun", 0);

        // Reset mid-ACCUM with a beat entering stage 1.
        start_product();
        send_beat(13'd300, {LANES{2'b01}}, 1'b0);
        send_beat(13'd400, {LANES{2'b11}}, 1'b0);
        in_valid = 1'b1; in_coef = 13'd500; in_tern = {LANES{2'b01}};
        rst_n = 1'b0;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        check_reset_state("midreset");
        start_product();
        send_beat(13'd3, {LANES{2'b01}}, 1'b1);
        collect("after_reset", 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
